// File: rtl/spi_fir_cmd_seq_if.sv
// Byte-level SPI slave and FIR handshake bundle for spi_fir_cmd_seq.
// master = sequencer side, slave = SPI_slave/FIR side.
interface spi_fir_cmd_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              i_rx_valid;
    logic [7:0]        i_rx_data;
    logic              i_ssel_active;
    logic              o_tx_load;
    logic [7:0]        o_tx_data;
    logic              o_coef_we;
    logic [ADDR_W-1:0] o_coef_addr;
    logic [DATA_W-1:0] o_coef_data;
    logic              o_smp_valid;
    logic [DATA_W-1:0] o_smp_data;
    logic              i_smp_ready;
    logic              i_res_valid;
    logic [DATA_W-1:0] i_res_data;
    logic              o_err;

    modport master (
        input  i_rx_valid, i_rx_data, i_ssel_active, i_smp_ready, i_res_valid, i_res_data,
        output o_tx_load, o_tx_data, o_coef_we, o_coef_addr, o_coef_data,
        output o_smp_valid, o_smp_data, o_err
    );

    modport slave (
        output i_rx_valid, i_rx_data, i_ssel_active, i_smp_ready, i_res_valid, i_res_data,
        input  o_tx_load, o_tx_data, o_coef_we, o_coef_addr, o_coef_data,
        input  o_smp_valid, o_smp_data, o_err
    );
endinterface

// File: rtl/spi_fir_cmd_seq.sv
// SPI byte-frame command sequencer driving FIR coefficient writes, sample pushes and result reads.
// Optional SPI_FIR_STATUS_EN turns cmd 00 into RD_STATUS; otherwise cmd 00 is a NOP.
module spi_fir_cmd_seq #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_fir_cmd_seq_if.master bus
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] FIRST_RD  = CNT_W'((NB > 1) ? NB - 2 : 0);
    localparam logic [6:0]       NTAPS_L   = 7'(NTAPS);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_COEF = 2'b01;
    localparam logic [1:0] CMD_SMP  = 2'b10;
    localparam logic [1:0] CMD_RES  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_COMMIT, S_READ} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_kind;
    logic [5:0]        r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_snap;
    logic              r_err;
    logic              r_tx_load;
    logic [7:0]        r_tx_data;
`ifdef SPI_FIR_STATUS_EN
    logic              r_fresh;
`endif

    logic              w_err_set;
    logic              w_addr_ok;
    logic              w_coef_we;
    logic              w_smp_valid;
    logic [7:0]        w_snap_byte;

    // Legality uses the full 6-bit command field, not just the ADDR_W bits driven out.
    assign w_addr_ok   = ({1'b0, r_addr} < NTAPS_L);
    assign w_coef_we   = (r_state == S_COMMIT) && (r_kind == CMD_COEF) && w_addr_ok;
    assign w_smp_valid = (r_state == S_COMMIT) && (r_kind == CMD_SMP);
    assign w_snap_byte = r_snap[{r_cnt, 3'b000} +: 8];

    assign bus.o_tx_load   = r_tx_load;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_coef_we   = w_coef_we;
    assign bus.o_coef_addr = r_addr[ADDR_W-1:0];
    assign bus.o_coef_data = r_shadow;
    assign bus.o_smp_valid = w_smp_valid;
    assign bus.o_smp_data  = r_shadow;
    assign bus.o_err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data[7:6])
                        CMD_COEF, CMD_SMP: w_next_state = S_PAYLOAD;
                        CMD_RES:           w_next_state = (NB == 1) ? S_IDLE : S_READ;
                        default:           w_next_state = S_IDLE;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (!bus.i_ssel_active) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end else if (bus.i_rx_valid && (r_cnt == LAST_BYTE)) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // Deselect is ignored here: the transaction always completes.
                if (bus.i_rx_valid) w_err_set = 1'b1;
                if (r_kind == CMD_SMP) begin
                    if (bus.i_smp_ready) w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_IDLE;
                    if (!w_addr_ok) w_err_set = 1'b1;
                end
            end
            S_READ: begin
                if (!bus.i_ssel_active) begin
                    w_next_state = S_IDLE;
                    w_err_set    = 1'b1;
                end else if (bus.i_rx_valid && (r_cnt == '0)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kind    <= CMD_NOP;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_result  <= '0;
            r_snap    <= '0;
            r_err     <= 1'b0;
            r_tx_load <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_load <= 1'b0;
            if (bus.i_res_valid) r_result <= bus.i_res_data;
            if (w_err_set)       r_err    <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_rx_valid) begin
                        r_kind   <= bus.i_rx_data[7:6];
                        r_addr   <= bus.i_rx_data[5:0];
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        if (bus.i_rx_data[7:6] == CMD_RES) begin
                            r_snap    <= r_result;
                            r_cnt     <= FIRST_RD;
                            r_tx_load <= 1'b1;
                            r_tx_data <= r_result[DATA_W-1 -: 8];
                        end
`ifdef SPI_FIR_STATUS_EN
                        if (bus.i_rx_data[7:6] == CMD_NOP) begin
                            r_tx_load <= 1'b1;
                            r_tx_data <= {r_err, r_fresh, w_smp_valid, 5'b0};
                            r_err     <= 1'b0;
                        end
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (!bus.i_ssel_active) begin
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end else if (bus.i_rx_valid) begin
                        r_shadow <= DATA_W'({r_shadow, bus.i_rx_data});
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    // Each host byte clocked in pulls the next lower snapshot byte.
                    if (bus.i_ssel_active && bus.i_rx_valid) begin
                        r_tx_load <= 1'b1;
                        r_tx_data <= w_snap_byte;
                        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_FIR_STATUS_EN
    // A result arriving on the RD_RES decode cycle is newer than the snapshot, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fresh <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.i_rx_valid && (bus.i_rx_data[7:6] == CMD_RES))
                r_fresh <= 1'b0;
            if (bus.i_res_valid)
                r_fresh <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_fir_cmd_seq.sv
// Scenario bench for spi_fir_cmd_seq: expected strobes queued at stimulus time, observed ones queued by a monitor.
module tb_spi_fir_cmd_seq;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NTAPS  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_fir_cmd_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spi_fir_cmd_seq #(.DATA_W(DATA_W), .NTAPS(NTAPS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_coef[$];
    logic [ADDR_W+DATA_W-1:0] obs_coef[$];
    logic [7:0]               exp_tx[$];
    logic [7:0]               obs_tx[$];
    logic [DATA_W-1:0]        exp_smp[$];
    logic [DATA_W-1:0]        obs_smp[$];

    always @(negedge clk) begin
        if (bus.o_coef_we === 1'b1) obs_coef.push_back({bus.o_coef_addr, bus.o_coef_data});
        if (bus.o_tx_load === 1'b1) obs_tx.push_back(bus.o_tx_data);
        if (bus.o_smp_valid === 1'b1 && bus.i_smp_ready === 1'b1) obs_smp.push_back(bus.o_smp_data);
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        sync();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        idle(gap);
    endtask

    task automatic pulse_result(input logic [DATA_W-1:0] v);
        bus.i_res_valid = 1'b1;
        bus.i_res_data  = v;
        sync();
        bus.i_res_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sync();
    endtask

    task automatic clear_queues();
        exp_coef.delete(); obs_coef.delete();
        exp_tx.delete();   obs_tx.delete();
        exp_smp.delete();  obs_smp.delete();
    endtask

    function automatic logic [63:0] all_outputs();
        return {bus.o_tx_load, bus.o_tx_data, bus.o_coef_we, bus.o_coef_addr, bus.o_coef_data,
                bus.o_smp_valid, bus.o_smp_data, bus.o_err};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        n_checks++;
        if (all_outputs() !== 64'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", all_outputs());
            n_fail++;
        end
        sync();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sync();
            @(negedge clk);
            n_checks++;
            if (all_outputs() !== 64'd0) begin
                $display("FAIL idle_outputs: cycle %0d got %h expected 0", i, all_outputs());
                n_fail++;
            end
        end
        sync();
    endtask

    task automatic test_coef_write();
        clear_queues();
        exp_coef.push_back({4'h3, 16'h1234});
        send(8'h43, 1);
        send(8'h12, 1);
        send(8'h34, 0);
        @(negedge clk);
        n_checks++;
        if (bus.o_coef_we !== 1'b1) begin
            $display("FAIL coef_latency: coef_we %b expected 1", bus.o_coef_we);
            n_fail++;
        end
        idle(4);
        @(negedge clk);
        n_checks++;
        if (obs_coef.size() != exp_coef.size()) begin
            $display("FAIL coef_count: got %0d expected %0d", obs_coef.size(), exp_coef.size());
            n_fail++;
        end
        while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
            logic [ADDR_W+DATA_W-1:0] e, o;
            e = exp_coef.pop_front();
            o = obs_coef.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL coef_value: got %h expected %h", o, e);
                n_fail++;
            end
        end
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            $display("FAIL coef_err: got %b expected 0", bus.o_err);
            n_fail++;
        end
        sync();
    endtask

    task automatic test_sample_hold();
        clear_queues();
        bus.i_smp_ready = 1'b0;
        exp_smp.push_back(16'hABCD);
        send(8'h80, 1);
        send(8'hAB, 1);
        send(8'hCD, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.o_smp_valid !== 1'b1 || bus.o_smp_data !== 16'hABCD) begin
                $display("FAIL smp_hold: cycle %0d valid %b data %h expected 1 abcd",
                         i, bus.o_smp_valid, bus.o_smp_data);
                n_fail++;
            end
        end
        sync();
        bus.i_smp_ready = 1'b1;
        sync();
        bus.i_smp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_smp_valid !== 1'b0) begin
            $display("FAIL smp_drop: valid %b expected 0", bus.o_smp_valid);
            n_fail++;
        end
        n_checks++;
        if (obs_smp.size() != exp_smp.size()) begin
            $display("FAIL smp_count: got %0d expected %0d", obs_smp.size(), exp_smp.size());
            n_fail++;
        end
        while (exp_smp.size() > 0 && obs_smp.size() > 0) begin
            logic [DATA_W-1:0] e, o;
            e = exp_smp.pop_front();
            o = obs_smp.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL smp_value: got %h expected %h", o, e);
                n_fail++;
            end
        end
        sync();
    endtask

    task automatic test_read_result();
        clear_queues();
        pulse_result(16'hBEEF);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        send(8'hC0, 0);
        @(negedge clk);
        n_checks++;
        if (bus.o_tx_load !== 1'b1 || bus.o_tx_data !== 8'hBE) begin
            $display("FAIL read_first: tx_load %b data %h expected 1 be", bus.o_tx_load, bus.o_tx_data);
            n_fail++;
        end
        sync();
        pulse_result(16'h1111);
        idle(1);
        send(8'h00, 2);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h11);
        send(8'hC0, 2);
        send(8'h00, 2);
        @(negedge clk);
        n_checks++;
        if (obs_tx.size() != exp_tx.size()) begin
            $display("FAIL tx_count: got %0d expected %0d", obs_tx.size(), exp_tx.size());
            n_fail++;
        end
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            logic [7:0] e, o;
            e = exp_tx.pop_front();
            o = obs_tx.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL tx_value: got %h expected %h", o, e);
                n_fail++;
            end
        end
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            $display("FAIL read_err: got %b expected 0", bus.o_err);
            n_fail++;
        end
        sync();
    endtask

    task automatic test_abort();
        do_reset();
        clear_queues();
        send(8'h45, 1);
        send(8'h12, 1);
        bus.i_ssel_active = 1'b0;
        sync();
        bus.i_ssel_active = 1'b1;
        idle(3);
        @(negedge clk);
        n_checks++;
        if (obs_coef.size() != 0 || bus.o_err !== 1'b1) begin
            $display("FAIL abort: strobes %0d err %b expected 0 1", obs_coef.size(), bus.o_err);
            n_fail++;
        end
        sync();
        exp_coef.push_back({4'h2, 16'hAA55});
        send(8'h42, 1);
        send(8'hAA, 1);
        send(8'h55, 3);
        @(negedge clk);
        n_checks++;
        if (obs_coef.size() != exp_coef.size()) begin
            $display("FAIL post_abort_count: got %0d expected %0d", obs_coef.size(), exp_coef.size());
            n_fail++;
        end
        while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
            logic [ADDR_W+DATA_W-1:0] e, o;
            e = exp_coef.pop_front();
            o = obs_coef.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL post_abort_value: got %h expected %h", o, e);
                n_fail++;
            end
        end
        sync();
    endtask

    task automatic test_illegal_addr();
        do_reset();
        clear_queues();
        send(8'h5F, 1);
        send(8'h12, 1);
        send(8'h34, 3);
        @(negedge clk);
        n_checks++;
        if (obs_coef.size() != 0 || bus.o_err !== 1'b1) begin
            $display("FAIL illegal_addr: strobes %0d err %b expected 0 1", obs_coef.size(), bus.o_err);
            n_fail++;
        end
        sync();
    endtask

    task automatic test_commit_rx();
        do_reset();
        clear_queues();
        bus.i_smp_ready = 1'b0;
        send(8'h80, 1);
        send(8'h12, 1);
        send(8'h34, 0);
        send(8'h99, 0);
        @(negedge clk);
        n_checks++;
        if (bus.o_smp_valid !== 1'b1 || bus.o_smp_data !== 16'h1234 || bus.o_err !== 1'b1) begin
            $display("FAIL commit_rx: valid %b data %h err %b expected 1 1234 1",
                     bus.o_smp_valid, bus.o_smp_data, bus.o_err);
            n_fail++;
        end
        sync();
        rst = 1'b1;
        sync();
        @(negedge clk);
        n_checks++;
        if (bus.o_smp_valid !== 1'b0 || bus.o_err !== 1'b0) begin
            $display("FAIL mid_reset: valid %b err %b expected 0 0", bus.o_smp_valid, bus.o_err);
            n_fail++;
        end
        sync();
        rst = 1'b0;
        sync();
        n_checks++;
        if (obs_smp.size() != 0) begin
            $display("FAIL mid_reset_accept: got %0d expected 0", obs_smp.size());
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_queues();
        bus.i_smp_ready = 1'b1;
        exp_coef.push_back({4'h0, 16'h0001});
        exp_coef.push_back({4'hF, 16'hFFFF});
        exp_smp.push_back(16'h7FFF);
        exp_tx.push_back(8'h80);
        exp_tx.push_back(8'h01);
        send(8'h40, 0); send(8'h00, 0); send(8'h01, 1);
        send(8'h4F, 0); send(8'hFF, 0); send(8'hFF, 1);
        send(8'h80, 0); send(8'h7F, 0); send(8'hFF, 1);
        pulse_result(16'h8001);
        send(8'hC0, 0);
        send(8'h00, 2);
        bus.i_smp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_coef.size() != exp_coef.size() || obs_smp.size() != exp_smp.size()
            || obs_tx.size() != exp_tx.size()) begin
            $display("FAIL b2b_counts: coef %0d smp %0d tx %0d expected %0d %0d %0d",
                     obs_coef.size(), obs_smp.size(), obs_tx.size(),
                     exp_coef.size(), exp_smp.size(), exp_tx.size());
            n_fail++;
        end
        while (exp_coef.size() > 0 && obs_coef.size() > 0) begin
            logic [ADDR_W+DATA_W-1:0] e, o;
            e = exp_coef.pop_front();
            o = obs_coef.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL b2b_coef: got %h expected %h", o, e);
                n_fail++;
            end
        end
        while (exp_smp.size() > 0 && obs_smp.size() > 0) begin
            logic [DATA_W-1:0] e, o;
            e = exp_smp.pop_front();
            o = obs_smp.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL b2b_smp: got %h expected %h", o, e);
                n_fail++;
            end
        end
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            logic [7:0] e, o;
            e = exp_tx.pop_front();
            o = obs_tx.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL b2b_tx: got %h expected %h", o, e);
                n_fail++;
            end
        end
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            $display("FAIL b2b_err: got %b expected 0", bus.o_err);
            n_fail++;
        end
        sync();
    endtask

`ifdef SPI_FIR_STATUS_EN
    task automatic test_status();
        do_reset();
        clear_queues();
        send(8'h45, 1);
        bus.i_ssel_active = 1'b0;
        sync();
        bus.i_ssel_active = 1'b1;
        idle(2);
        exp_tx.push_back(8'h80);
        send(8'h00, 1);
        @(negedge clk);
        n_checks++;
        if (bus.o_err !== 1'b0) begin
            $display("FAIL status_clear: err %b expected 0", bus.o_err);
            n_fail++;
        end
        sync();
        pulse_result(16'h0042);
        exp_tx.push_back(8'h40);
        send(8'h00, 2);
        @(negedge clk);
        n_checks++;
        if (obs_tx.size() != exp_tx.size()) begin
            $display("FAIL status_count: got %0d expected %0d", obs_tx.size(), exp_tx.size());
            n_fail++;
        end
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            logic [7:0] e, o;
            e = exp_tx.pop_front();
            o = obs_tx.pop_front();
            n_checks++;
            if (o !== e) begin
                $display("FAIL status_value: got %h expected %h", o, e);
                n_fail++;
            end
        end
        sync();
    endtask
`else
    task automatic test_nop();
        do_reset();
        clear_queues();
        send(8'h00, 2);
        send(8'h3F, 2);
        @(negedge clk);
        n_checks++;
        if (obs_tx.size() != 0 || obs_coef.size() != 0 || bus.o_smp_valid !== 1'b0
            || bus.o_err !== 1'b0) begin
            $display("FAIL nop: tx %0d coef %0d smp_valid %b err %b expected 0 0 0 0",
                     obs_tx.size(), obs_coef.size(), bus.o_smp_valid, bus.o_err);
            n_fail++;
        end
        sync();
    endtask
`endif

    initial begin
        bus.i_rx_valid    = 1'b0;
        bus.i_rx_data     = 8'h00;
        bus.i_ssel_active = 1'b1;
        bus.i_smp_ready   = 1'b0;
        bus.i_res_valid   = 1'b0;
        bus.i_res_data    = '0;
        #1;
        test_reset();
        test_coef_write();
        test_sample_hold();
        test_read_result();
        test_abort();
        test_illegal_addr();
        test_commit_rx();
        test_back_to_back();
`ifdef SPI_FIR_STATUS_EN
        test_status();
`else
        test_nop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
